// File: rtl/kp_setpoint_ctrl.sv
// Keypad setpoint/run controller: edits BCD time/duty fields, validates and converts them,
// and hands them to the timer/PWM side through a write/write_ack handshake.
module kp_setpoint_ctrl #(
   parameter int unsigned DIGITS   = 3,
   parameter int unsigned NFIELDS  = 2,
   parameter int unsigned DEBOUNCE = 1023,
   parameter int unsigned MAX_DC   = 100
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [3:0]                      num,
   input  logic                            kphit,
   input  logic                            write_ack,
   input  logic [4*DIGITS-1:0]             tLED,
   output logic                            start,
   output logic                            stop,
   output logic                            write,
   output logic                            err,
   output logic [$clog2(NFIELDS)-1:0]      sel,
   output logic [NFIELDS*4*DIGITS-1:0]     fields,
   output logic [9:0]                      Time,
   output logic [8*(NFIELDS-1)-1:0]        DC
);

   localparam int unsigned FW = 4 * DIGITS;
   localparam int unsigned SW = $clog2(NFIELDS);
   localparam int unsigned CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

   typedef enum logic [1:0] {STOPPED, WAIT_ACK, RUN} state_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q;
   logic [NFIELDS*FW-1:0]  fields_q, fields_d;
   logic [SW-1:0]          sel_q, sel_d;
   logic                   write_q, write_d;
   logic                   start_q, start_d;
   logic                   stop_q, stop_d;
   logic                   err_q, err_d;

   logic                   accept;
   logic                   is_digit;
   logic [31:0]            base;
   logic [FW-1:0]          cur;
   logic [15:0]            t_pad;
   logic [11:0]            d_pad;
   logic [9:0]             dc_raw;

   assign accept   = kphit && (cnt_q == '0);
   assign is_digit = (num <= 4'd9);
   assign base     = 32'(sel_q) * FW;
   assign cur      = fields_q[base +: FW];

   // Field 0 digit weights 1,10,60,600; 10-bit wrap matches the Time port width.
   always_comb begin
      t_pad = 16'(fields_q[FW-1:0]);
      Time  = 10'(t_pad[3:0]) + 10'(t_pad[7:4]) * 10'd10
            + 10'(t_pad[11:8]) * 10'd60 + 10'(t_pad[15:12]) * 10'd600;
   end

   always_comb begin
      DC     = '0;
      d_pad  = '0;
      dc_raw = '0;
      for (int unsigned k = 1; k < NFIELDS; k++) begin
         d_pad  = 12'(fields_q[k*FW +: FW]);
         dc_raw = 10'(d_pad[3:0]) + 10'(d_pad[7:4]) * 10'd10 + 10'(d_pad[11:8]) * 10'd100;
         DC[(k-1)*8 +: 8] = (dc_raw > 10'(MAX_DC)) ? 8'(MAX_DC) : dc_raw[7:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      fields_d = fields_q;
      sel_d    = sel_q;
      write_d  = write_q;
      start_d  = start_q;
      stop_d   = stop_q;
      err_d    = 1'b0;
      case (state_q)
         STOPPED: begin
            if (accept) begin
               case (num)
                  4'hA: fields_d[FW-1:0] = tLED;
                  4'hB: begin
                     if (Time != '0) begin
                        write_d = 1'b1;
                        state_d = WAIT_ACK;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  4'hC: sel_d = (sel_q == SW'(NFIELDS - 1)) ? '0 : sel_q + SW'(1);
                  4'hD: fields_d[base +: FW] = '0;
                  4'hE: fields_d[base +: FW] = {4'h0, cur[FW-1:4]};
                  default: begin
                     if (is_digit) begin
                        // Old units digit becomes tens-of-seconds after the shift.
                        if ((sel_q == '0) && (cur[3:0] > 4'd5))
                           err_d = 1'b1;
                        else
                           fields_d[base +: FW] = {cur[FW-5:0], num};
                     end
                  end
               endcase
            end
         end
         WAIT_ACK: begin
            if (accept && (num == 4'hA)) begin
               write_d = 1'b0;
               state_d = STOPPED;
            end else if (write_ack) begin
               write_d = 1'b0;
               start_d = 1'b1;
               stop_d  = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept && (num == 4'hA)) begin
               start_d           = 1'b0;
               stop_d            = 1'b1;
               fields_d[FW-1:0]  = tLED;
               state_d           = STOPPED;
            end
         end
         default: state_d = STOPPED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= STOPPED;
         cnt_q    <= '0;
         fields_q <= '0;
         sel_q    <= '0;
         write_q  <= 1'b0;
         start_q  <= 1'b0;
         stop_q   <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fields_q <= fields_d;
         sel_q    <= sel_d;
         write_q  <= write_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         err_q    <= err_d;
         if (accept)
            cnt_q <= CW'(DEBOUNCE);
         else if (cnt_q != '0)
            cnt_q <= cnt_q - CW'(1);
      end
   end

   assign start  = start_q;
   assign stop   = stop_q;
   assign write  = write_q;
   assign err    = err_q;
   assign sel    = sel_q;
   assign fields = fields_q;

endmodule

// File: tb/tb_kp_setpoint_ctrl.sv
// Self-checking bench for kp_setpoint_ctrl: key-press vector table with a scoreboard queue,
// plus hand-written handshake, reset and key-hold sequences.
module tb_kp_setpoint_ctrl;

   localparam int unsigned DIGITS   = 3;
   localparam int unsigned NFIELDS  = 2;
   localparam int unsigned DEBOUNCE = 1023;
   localparam int unsigned MAX_DC   = 100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  num;
   logic        kphit;
   logic        write_ack;
   logic [11:0] tLED;
   logic        start, stop, write, err;
   logic        sel;
   logic [23:0] fields;
   logic [9:0]  Time;
   logic [7:0]  DC;

   kp_setpoint_ctrl #(
      .DIGITS(DIGITS), .NFIELDS(NFIELDS), .DEBOUNCE(DEBOUNCE), .MAX_DC(MAX_DC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .num(num), .kphit(kphit), .write_ack(write_ack),
      .tLED(tLED), .start(start), .stop(stop), .write(write), .err(err), .sel(sel),
      .fields(fields), .Time(Time), .DC(DC)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  key;
      logic        ack;
      logic [11:0] tled;
      logic [11:0] f0;
      logic [11:0] f1;
      logic        sel;
      logic [9:0]  tm;
      logic [7:0]  dc;
      logic        err;
      logic        wr;
      logic        st;
      logic        sp;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   nchk = 0;
   int   nerr = 0;
   int   err_pulses = 0;
   int   sel_changes = 0;
   logic sel_prev = 1'b0;

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (err === 1'b1) err_pulses++;
         if (sel !== sel_prev) sel_changes++;
      end
      sel_prev = sel;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] key, input logic ack, input logic [11:0] tled,
                      input logic [11:0] f0, input logic [11:0] f1, input logic s,
                      input logic [9:0] tm, input logic [7:0] dc, input logic e,
                      input logic wr, input logic st, input logic sp);
      vec_t v;
      v.key = key; v.ack = ack; v.tled = tled; v.f0 = f0; v.f1 = f1; v.sel = s;
      v.tm = tm; v.dc = dc; v.err = e; v.wr = wr; v.st = st; v.sp = sp;
      tbl.push_back(v);
   endtask

   task automatic compare_pop(input int idx);
      vec_t e;
      string t;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      t = $sformatf("v%0d", idx);
      check({t, "_f0"},    32'(fields[11:0]),  32'(e.f0));
      check({t, "_f1"},    32'(fields[23:12]), 32'(e.f1));
      check({t, "_sel"},   32'(sel),   32'(e.sel));
      check({t, "_time"},  32'(Time),  32'(e.tm));
      check({t, "_dc"},    32'(DC),    32'(e.dc));
      check({t, "_err"},   32'(err),   32'(e.err));
      check({t, "_write"}, 32'(write), 32'(e.wr));
      check({t, "_start"}, 32'(start), 32'(e.st));
      check({t, "_stop"},  32'(stop),  32'(e.sp));
   endtask

   task automatic apply(input int idx);
      vec_t v;
      v = tbl[idx];
      sb.push_back(v);
      @(negedge clk);
      num = v.key; kphit = 1'b1; write_ack = v.ack; tLED = v.tled;
      @(posedge clk);
      #1;
      kphit = 1'b0; write_ack = 1'b0;
      compare_pop(idx);
      repeat (DEBOUNCE) @(posedge clk);
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      write_ack = 1'b1;
      @(posedge clk);
      #1;
      write_ack = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check({name, "_fields"}, 32'(fields), 32'd0);
      check({name, "_sel"},    32'(sel),    32'd0);
      check({name, "_start"},  32'(start),  32'd0);
      check({name, "_stop"},   32'(stop),   32'd1);
      check({name, "_write"},  32'(write),  32'd0);
      check({name, "_err"},    32'(err),    32'd0);
      check({name, "_time"},   32'(Time),   32'd0);
      check({name, "_dc"},     32'(DC),     32'd0);
   endtask

   int e0, s0, exp_err;

   initial begin
      reset_n = 1'b0; num = 4'h0; kphit = 1'b0; write_ack = 1'b0; tLED = 12'h045;

      //   key   ack tled    f0      f1      sel tm   dc   err wr st sp
      add(4'h1, 0, 12'h045, 12'h001, 12'h000, 0, 1,   0,   0, 0, 0, 1); // 0
      add(4'h3, 0, 12'h045, 12'h013, 12'h000, 0, 13,  0,   0, 0, 0, 1);
      add(4'h0, 0, 12'h045, 12'h130, 12'h000, 0, 90,  0,   0, 0, 0, 1);
      add(4'hD, 0, 12'h045, 12'h000, 12'h000, 0, 0,   0,   0, 0, 0, 1);
      add(4'h1, 0, 12'h045, 12'h001, 12'h000, 0, 1,   0,   0, 0, 0, 1);
      add(4'h7, 0, 12'h045, 12'h017, 12'h000, 0, 17,  0,   0, 0, 0, 1); // 5
      add(4'h7, 0, 12'h045, 12'h017, 12'h000, 0, 17,  0,   1, 0, 0, 1); // tens would be 7
      add(4'hE, 0, 12'h045, 12'h001, 12'h000, 0, 1,   0,   0, 0, 0, 1);
      add(4'hE, 0, 12'h045, 12'h000, 12'h000, 0, 0,   0,   0, 0, 0, 1);
      add(4'hB, 0, 12'h045, 12'h000, 12'h000, 0, 0,   0,   1, 0, 0, 1); // zero time start
      add(4'h1, 0, 12'h045, 12'h001, 12'h000, 0, 1,   0,   0, 0, 0, 1); // 10
      add(4'h3, 0, 12'h045, 12'h013, 12'h000, 0, 13,  0,   0, 0, 0, 1);
      add(4'h0, 0, 12'h045, 12'h130, 12'h000, 0, 90,  0,   0, 0, 0, 1);
      add(4'hC, 0, 12'h045, 12'h130, 12'h000, 1, 90,  0,   0, 0, 0, 1);
      add(4'h5, 0, 12'h045, 12'h130, 12'h005, 1, 90,  5,   0, 0, 0, 1);
      add(4'h0, 0, 12'h045, 12'h130, 12'h050, 1, 90,  50,  0, 0, 0, 1); // 15
      add(4'h9, 0, 12'h045, 12'h130, 12'h509, 1, 90,  100, 0, 0, 0, 1); // saturates
      add(4'hD, 0, 12'h045, 12'h130, 12'h000, 1, 90,  0,   0, 0, 0, 1);
      add(4'h9, 0, 12'h045, 12'h130, 12'h009, 1, 90,  9,   0, 0, 0, 1);
      add(4'h7, 0, 12'h045, 12'h130, 12'h097, 1, 90,  97,  0, 0, 0, 1); // duty: no validation
      add(4'hC, 0, 12'h045, 12'h130, 12'h097, 0, 90,  97,  0, 0, 0, 1); // 20
      add(4'hC, 0, 12'h045, 12'h130, 12'h097, 1, 90,  97,  0, 0, 0, 1);
      add(4'hD, 0, 12'h045, 12'h130, 12'h000, 1, 90,  0,   0, 0, 0, 1);
      add(4'h5, 0, 12'h045, 12'h130, 12'h005, 1, 90,  5,   0, 0, 0, 1);
      add(4'h0, 0, 12'h045, 12'h130, 12'h050, 1, 90,  50,  0, 0, 0, 1);
      add(4'hF, 0, 12'h045, 12'h130, 12'h050, 1, 90,  50,  0, 0, 0, 1); // 25 unused key
      add(4'hA, 0, 12'h102, 12'h102, 12'h050, 1, 62,  50,  0, 0, 0, 1); // reload in STOPPED
      add(4'hB, 0, 12'h102, 12'h102, 12'h050, 1, 62,  50,  0, 1, 0, 1); // -> WAIT_ACK
      add(4'h2, 0, 12'h045, 12'h102, 12'h050, 1, 62,  50,  0, 1, 0, 1);
      add(4'hC, 0, 12'h045, 12'h102, 12'h050, 1, 62,  50,  0, 1, 0, 1);
      // 30.. RUN after hand-driven ack
      add(4'h4, 0, 12'h045, 12'h102, 12'h050, 1, 62,  50,  0, 0, 1, 0);
      add(4'hD, 0, 12'h045, 12'h102, 12'h050, 1, 62,  50,  0, 0, 1, 0);
      add(4'hB, 0, 12'h045, 12'h102, 12'h050, 1, 62,  50,  0, 0, 1, 0);
      add(4'hC, 0, 12'h045, 12'h102, 12'h050, 1, 62,  50,  0, 0, 1, 0);
      add(4'hA, 0, 12'h045, 12'h045, 12'h050, 1, 45,  50,  0, 0, 0, 1); // stop, reload
      // 35.. abort handshakes
      add(4'hB, 0, 12'h045, 12'h045, 12'h050, 1, 45,  50,  0, 1, 0, 1);
      add(4'hA, 0, 12'h045, 12'h045, 12'h050, 1, 45,  50,  0, 0, 0, 1); // A before ack
      add(4'hB, 0, 12'h045, 12'h045, 12'h050, 1, 45,  50,  0, 1, 0, 1);
      add(4'hA, 1, 12'h045, 12'h045, 12'h050, 1, 45,  50,  0, 0, 0, 1); // A beats ack
      add(4'h3, 0, 12'h045, 12'h045, 12'h503, 1, 45,  100, 0, 0, 0, 1);
      add(4'hB, 0, 12'h045, 12'h045, 12'h503, 1, 45,  100, 0, 1, 0, 1); // 40

      exp_err = 0;
      foreach (tbl[i]) if (tbl[i].err) exp_err++;

      repeat (3) @(posedge clk);
      #1;
      check_idle("reset_held");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle("reset_released");

      e0 = err_pulses;
      for (int i = 0; i <= 29; i++) apply(i);

      pulse_ack();
      check("ack_write", 32'(write), 32'd0);
      check("ack_start", 32'(start), 32'd1);
      check("ack_stop",  32'(stop),  32'd0);

      for (int i = 30; i <= 34; i++) apply(i);

      pulse_ack();
      check("stray_ack_write", 32'(write), 32'd0);
      check("stray_ack_start", 32'(start), 32'd0);
      check("stray_ack_stop",  32'(stop),  32'd1);

      for (int i = 35; i <= 40; i++) apply(i);
      @(negedge clk);
      check("err_pulse_count", 32'(err_pulses - e0), 32'(exp_err));
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      // Reset while RUN
      pulse_ack();
      check("run_start", 32'(start), 32'd1);
      @(negedge clk);
      reset_n = 1'b0;
      write_ack = 1'b1;
      @(posedge clk);
      #1;
      write_ack = 1'b0;
      check_idle("reset_in_run");
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle("after_run_reset");

      // Key held for 3000 cycles: accepts at cycles 0, 1024, 2048
      @(negedge clk);
      s0 = sel_changes;
      num = 4'hC;
      kphit = 1'b1;
      repeat (3000) @(posedge clk);
      #1;
      kphit = 1'b0;
      @(negedge clk);
      check("hold_accepts", 32'(sel_changes - s0), 32'd3);
      check("hold_sel",     32'(sel), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
